cdc_register_arbiter: RTL and testbench
=======================================

# cdc_register_arbiter

Round-robin arbiter that shares the write port of one `cdc_register` crossing among several requesters in the write clock domain. Each requester offers a word with a valid/ready handshake. The arbiter captures the winner's word, tags it with the requester index, and holds `wr` until the crossing accepts it. It sits between the write-side clients and `cdc_register`, whose `data_width` is set to `data_width + source_width`.

## Interface
Parameters:
- `num_requesters`, 4: number of requesters, legal range 1..16.
- `data_width`, 32: payload width per requester.
- `source_width`, `max(1, $clog2(num_requesters))`: derived, width of the source tag.

Ports:
- `clk`  input  1: write-domain clock; all logic is on its rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `req_valid`  input  num_requesters: requester i offers a word.
- `req_data`  input  num_requesters*data_width: word of requester i is bits [i*data_width +: data_width].
- `req_ready`  output  num_requesters: one-hot acceptance; the word is taken when `req_valid[i] && req_ready[i]`.
- `wr_data`  output  data_width: held payload, to `cdc_register.wr_data` (low bits).
- `wr_source`  output  source_width: index of the requester that supplied `wr_data`, to `cdc_register.wr_data` (high bits).
- `wr`  output  1: write strobe, to `cdc_register.wr`.
- `wr_ready`  input  1: from `cdc_register.wr_ready`.
- `transfer_count`  output  16: number of words accepted by the crossing; wraps modulo 2^16.

## Operation
- The state machine has two states, IDLE and SEND.
- IDLE:
  - `wr` = 0.
  - The grant is chosen combinationally: the first i with `req_valid[i]`=1, searching from `last_grant+1` upward and wrapping modulo `num_requesters`.
  - `req_ready` is one-hot on that grant, and all zero if no `req_valid` is set.
  - When a grant exists, at the clock edge:
    - capture the word into `wr_data` and the index into `wr_source`;
    - set `last_grant` to the granted index;
    - go to SEND.
- SEND:
  - `wr` = 1 and `req_ready` = 0.
  - `wr_data` and `wr_source` hold steady.
  - On an edge with `wr_ready`=1:
    - `transfer_count` increments;
    - the state goes to IDLE.
  - Otherwise the state stays in SEND indefinitely; there is no timeout.
- `req_ready` depends only on state, `last_grant` and `req_valid`. It never depends on `req_data` or `wr_ready`.
- A requester must hold `req_valid` and `req_data` stable until it is accepted. Dropping `req_valid` before acceptance withdraws the request harmlessly.
- `num_requesters`=1: the grant is always 0 and `wr_source` is always 0 (1 bit wide).
- `transfer_count` wraps from 0xFFFF to 0x0000.

## Timing
- Reset values:
  - state IDLE;
  - `last_grant` = `num_requesters`-1, so requester 0 has first priority;
  - `wr` 0, `req_ready` 0, `wr_data` 0, `wr_source` 0, `transfer_count` 0.
- While `reset` is high, `req_ready` is forced to 0.
- Accept in cycle N puts `wr`=1 with the captured data from cycle N+1.
- `wr`=1 and `wr_ready`=1 at the edge ending cycle M gives `wr`=0 in cycle M+1. That cycle is IDLE, so a new acceptance is possible in M+1 and the next `wr` comes in M+2.
- Minimum spacing between accepts is 2 cycles. Actual throughput is bounded by the crossing's handshake.
- `wr_ready` sampled while in IDLE is ignored.
- Reset asserted in SEND:
  - the held word is discarded;
  - `wr`=0 from the next cycle;
  - the requester already saw `req_ready`, so the word is lost. This is accepted behaviour.
- Simultaneous requests: exactly one grant per accept. A requester that is continuously valid waits at most `num_requesters`-1 other transfers.

## Test plan
- Single request:
  - Stimulus: reset, then `req_valid`=4'b0100 with `req_data[2]`=0xDEADBEEF, `wr_ready`=1.
  - Required: `req_ready`=4'b0100 the same cycle; next cycle `wr`=1, `wr_data`=0xDEADBEEF, `wr_source`=2; then `wr`=0 and `transfer_count`=1.
- Round-robin fairness:
  - Stimulus: all four requesters held valid, `wr_ready` always 1.
  - Required: grant order 0,1,2,3,0,1; `transfer_count`=6 after six transfers.
- Backpressure:
  - Stimulus: `wr_ready`=0 for 10 cycles after `wr` rises, then 1.
  - Required: `wr`, `wr_data` and `wr_source` stay constant for 10 cycles; `req_ready` stays 0 throughout; exactly one increment of `transfer_count`.
- Priority rotation after a gap:
  - Stimulus: grant 3, then requesters 1 and 3 both valid.
  - Required: grant goes to 1, then to 3.
- Reset mid-SEND:
  - Stimulus: assert `reset` while `wr`=1 and `wr_ready`=0.
  - Required: next cycle `wr`=0, `wr_source`=0 and `transfer_count`=0; the next accept goes to requester 0 first.
- Wrap:
  - Stimulus: preload by 65536 transfers.
  - Required: `transfer_count` returns to 0x0000.

Source files
------------

// File: rtl/cdc_register_arbiter.sv
// Round-robin arbiter that shares the write port of one cdc_register crossing.
// The winning word is captured with its source tag and held until the crossing accepts it.
module cdc_register_arbiter #(
  parameter int num_requesters = 4,
  parameter int data_width     = 32,
  parameter int source_width   = (num_requesters > 1) ? $clog2(num_requesters) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [num_requesters-1:0]            req_valid,
  input  logic [num_requesters*data_width-1:0] req_data,
  output logic [num_requesters-1:0]            req_ready,
  output logic [data_width-1:0]                wr_data,
  output logic [source_width-1:0]              wr_source,
  output logic                                 wr,
  input  logic                                 wr_ready,
  output logic [15:0]                          transfer_count
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [source_width-1:0] last_grant;
  logic [source_width-1:0] grant;
  logic [source_width-1:0] idx;
  int unsigned             cand;
  logic                    grant_found;
  logic                    accept;
  logic [data_width-1:0]   words [num_requesters];

  for (genvar i = 0; i < num_requesters; i++) begin : g_unpack
    assign words[i] = req_data[i*data_width +: data_width];
  end

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand        = 0;
    idx         = '0;
    for (int unsigned k = 1; k <= 32'(num_requesters); k++) begin
      cand = (32'(last_grant) + k) % 32'(num_requesters);
      idx  = source_width'(cand);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant       = idx;
      end
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    wr         = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          next_state = SEND;
          if (!reset) begin
            req_ready[grant] = 1'b1;
          end
        end
      end
      SEND: begin
        wr = 1'b1;
        if (wr_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && grant_found;

  // Reset discards any held word; the requester already saw its ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= source_width'(num_requesters - 1);
      wr_data        <= '0;
      wr_source      <= '0;
      transfer_count <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        wr_data    <= words[grant];
        wr_source  <= grant;
        last_grant <= grant;
      end
      if ((state == SEND) && wr_ready) begin
        transfer_count <= transfer_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdc_register_arbiter.sv
// Self-checking bench for cdc_register_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_cdc_register_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   wr_data;
  logic [1:0]      wr_source;
  logic            wr;
  logic            wr_ready;
  logic [15:0]     transfer_count;

  int checks = 0;
  int fails  = 0;

  cdc_register_arbiter #(
    .num_requesters(N),
    .data_width    (DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .wr_data       (wr_data),
    .wr_source     (wr_source),
    .wr            (wr),
    .wr_ready      (wr_ready),
    .transfer_count(transfer_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    wr_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_data  = '1;
    wr_ready  = 1'b1;
    tick();
    tick();
    #1;
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (wr !== 1'b0) begin fails++; $display("[TB] FAIL reset_wr: got %b expected 0", wr); end
    checks++; if (wr_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data); end
    checks++; if (wr_source !== 2'd0) begin fails++; $display("[TB] FAIL reset_wr_source: got %0d expected 0", wr_source); end
    checks++; if (transfer_count !== 16'h0) begin fails++; $display("[TB] FAIL reset_count: got %h expected 0", transfer_count); end
    reset     = 1'b0;
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    req_data  = '0;
    req_data[2*DW +: DW] = 32'hDEADBEEF;
    wr_ready  = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin fails++; $display("[TB] FAIL single_ready: got %b expected 0100", req_ready); end
    checks++; if (wr !== 1'b0) begin fails++; $display("[TB] FAIL single_wr_idle: got %b expected 0", wr); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (wr !== 1'b1) begin fails++; $display("[TB] FAIL single_wr: got %b expected 1", wr); end
    checks++; if (wr_data !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL single_data: got %h expected deadbeef", wr_data); end
    checks++; if (wr_source !== 2'd2) begin fails++; $display("[TB] FAIL single_source: got %0d expected 2", wr_source); end
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("[TB] FAIL single_ready_send: got %b expected 0000", req_ready); end
    tick();
    checks++; if (wr !== 1'b0) begin fails++; $display("[TB] FAIL single_wr_done: got %b expected 0", wr); end
    checks++; if (transfer_count !== 16'd1) begin fails++; $display("[TB] FAIL single_count: got %0d expected 1", transfer_count); end
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hA000_0000 + i;
    req_valid = 4'b1111;
    wr_ready  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      g = k % N;
      #1;
      checks++; if (req_ready !== 4'(1 << g)) begin fails++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, 4'(1 << g)); end
      tick();
      checks++; if (wr !== 1'b1 || wr_source !== 2'(g) || wr_data !== 32'hA000_0000 + g) begin
        fails++; $display("[TB] FAIL rr_grant[%0d]: got wr=%b src=%0d data=%h expected wr=1 src=%0d data=%h", k, wr, wr_source, wr_data, g, 32'hA000_0000 + g);
      end
      tick();
    end
    req_valid = '0;
    #1;
    checks++; if (transfer_count !== 16'd6) begin fails++; $display("[TB] FAIL rr_count: got %0d expected 6", transfer_count); end
  endtask

  task automatic test_backpressure();
    req_data[0] = 1'b0;
    req_data[0*DW +: DW] = 32'h12345678;
    req_valid = 4'b0001;
    wr_ready  = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL bp_ready: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (wr !== 1'b1 || wr_data !== 32'h12345678 || wr_source !== 2'd0) begin
        fails++; $display("[TB] FAIL bp_hold[%0d]: got wr=%b data=%h src=%0d expected wr=1 data=12345678 src=0", i, wr, wr_data, wr_source);
      end
      checks++; if (req_ready !== 4'b0000 || transfer_count !== 16'd6) begin
        fails++; $display("[TB] FAIL bp_stall[%0d]: got ready=%b count=%0d expected ready=0000 count=6", i, req_ready, transfer_count);
      end
      tick();
    end
    wr_ready = 1'b1;
    #1;
    checks++; if (wr !== 1'b1) begin fails++; $display("[TB] FAIL bp_wr_last: got %b expected 1", wr); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (wr !== 1'b0 || transfer_count !== 16'd7) begin fails++; $display("[TB] FAIL bp_release: got wr=%b count=%0d expected wr=0 count=7", wr, transfer_count); end
    tick();
    checks++; if (wr !== 1'b0 || transfer_count !== 16'd7) begin fails++; $display("[TB] FAIL bp_idle_ready: got wr=%b count=%0d expected wr=0 count=7", wr, transfer_count); end
  endtask

  task automatic test_rotation();
    req_data[1*DW +: DW] = 32'h1111_1111;
    req_data[3*DW +: DW] = 32'h3333_3333;
    req_valid = 4'b1000;
    wr_ready  = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1000) begin fails++; $display("[TB] FAIL rot_first: got %b expected 1000", req_ready); end
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin fails++; $display("[TB] FAIL rot_to_1: got %b expected 0010", req_ready); end
    tick();
    req_valid = 4'b1000;
    #1;
    checks++; if (wr_source !== 2'd1 || wr_data !== 32'h1111_1111) begin fails++; $display("[TB] FAIL rot_src_1: got src=%0d data=%h expected 1/11111111", wr_source, wr_data); end
    tick();
    checks++; if (req_ready !== 4'b1000) begin fails++; $display("[TB] FAIL rot_to_3: got %b expected 1000", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (wr_source !== 2'd3 || wr_data !== 32'h3333_3333) begin fails++; $display("[TB] FAIL rot_src_3: got src=%0d data=%h expected 3/33333333", wr_source, wr_data); end
    tick();
    checks++; if (transfer_count !== 16'd10) begin fails++; $display("[TB] FAIL rot_count: got %0d expected 10", transfer_count); end
  endtask

  task automatic test_reset_mid_send();
    req_data[2*DW +: DW] = 32'hCAFE_F00D;
    req_valid = 4'b0100;
    wr_ready  = 1'b0;
    tick();
    req_valid = '0;
    #1;
    checks++; if (wr !== 1'b1) begin fails++; $display("[TB] FAIL rms_send: got %b expected 1", wr); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    wr_ready  = 1'b1;
    #1;
    checks++; if (wr !== 1'b0 || wr_source !== 2'd0 || transfer_count !== 16'd0 || wr_data !== 32'h0) begin
      fails++; $display("[TB] FAIL rms_cleared: got wr=%b src=%0d count=%0d data=%h expected all 0", wr, wr_source, transfer_count, wr_data);
    end
    checks++; if (req_ready !== 4'b0001) begin fails++; $display("[TB] FAIL rms_first_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    tick();
    checks++; if (transfer_count !== 16'd1) begin fails++; $display("[TB] FAIL rms_count: got %0d expected 1", transfer_count); end
  endtask

  task automatic test_random();
    int          m_last;
    bit          m_busy;
    logic [31:0] m_word;
    int          m_src;
    logic [15:0] m_count;
    logic [3:0]  exp_ready;
    logic [3:0]  accepted;
    int          g;
    do_reset();
    m_last = N - 1; m_busy = 0; m_word = '0; m_src = 0; m_count = '0; accepted = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || accepted[i]) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          req_data[i*DW +: DW] = $urandom;
        end
      end
      wr_ready = 1'($urandom_range(0, 1));
      #1;
      g = -1;
      exp_ready = '0;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      checks++; if (req_ready !== exp_ready || wr !== m_busy || transfer_count !== m_count) begin
        fails++; $display("[TB] FAIL rand_ctrl[%0d]: got ready=%b wr=%b count=%0d expected ready=%b wr=%b count=%0d", c, req_ready, wr, transfer_count, exp_ready, m_busy, m_count);
      end
      if (m_busy) begin
        checks++; if (wr_data !== m_word || wr_source !== 2'(m_src)) begin
          fails++; $display("[TB] FAIL rand_word[%0d]: got data=%h src=%0d expected data=%h src=%0d", c, wr_data, wr_source, m_word, m_src);
        end
      end
      accepted = '0;
      if (!m_busy && g >= 0) begin
        m_busy = 1; m_word = req_data[g*DW +: DW]; m_src = g; m_last = g; accepted[g] = 1'b1;
      end else if (m_busy && wr_ready) begin
        m_busy = 0; m_count = m_count + 16'd1;
      end
      tick();
    end
    req_valid = '0;
    wr_ready  = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    logic [15:0] e;
    req_valid = '0;
    wr_ready  = 1'b1;
    tick();
    force dut.transfer_count = 16'hFFFC;
    #1;
    release dut.transfer_count;
    #1;
    e = 16'hFFFC;
    checks++; if (transfer_count !== e) begin fails++; $display("[TB] FAIL wrap_preload: got %h expected %h", transfer_count, e); end
    req_data[0*DW +: DW] = 32'h0BAD_F00D;
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      e = e + 16'd1;
      checks++; if (transfer_count !== e) begin fails++; $display("[TB] FAIL wrap_step[%0d]: got %h expected %h", k, transfer_count, e); end
    end
    checks++; if (transfer_count !== 16'h0000) begin fails++; $display("[TB] FAIL wrap_zero: got %h expected 0000", transfer_count); end
    req_valid = '0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    wr_ready  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_rotation();
    test_reset_mid_send();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
